// File: rtl/traffic_light_pkg.sv
// Shared lamp encoding, direction indices, fault codes and monitor state
// encoding for the traffic light controller and its monitor.
package traffic_light_pkg;

   localparam int unsigned LAMP_W = 2;
   localparam int unsigned CODE_W = 3;
   localparam int unsigned DIR_W  = 2;
   localparam int unsigned ROT_W  = 8;
   localparam int unsigned NDIR   = 4;

   localparam logic [LAMP_W-1:0] RED    = 2'b00;
   localparam logic [LAMP_W-1:0] YELLOW = 2'b01;
   localparam logic [LAMP_W-1:0] GREEN  = 2'b10;

   localparam logic [DIR_W-1:0] DIR_NS = 2'd0;
   localparam logic [DIR_W-1:0] DIR_SN = 2'd1;
   localparam logic [DIR_W-1:0] DIR_EW = 2'd2;
   localparam logic [DIR_W-1:0] DIR_WE = 2'd3;

   localparam logic [CODE_W-1:0] FC_NONE        = 3'd0;
   localparam logic [CODE_W-1:0] FC_ILLEGAL     = 3'd1;
   localparam logic [CODE_W-1:0] FC_BAD_SEQ     = 3'd2;
   localparam logic [CODE_W-1:0] FC_CONFLICT    = 3'd3;
   localparam logic [CODE_W-1:0] FC_SHORT_GREEN = 3'd4;
   localparam logic [CODE_W-1:0] FC_STUCK       = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAULT = 2'd3
   } mon_state_t;

   // Lowest-index set direction of a per-direction flag vector.
   function automatic logic [DIR_W-1:0] lowest_dir(input logic [NDIR-1:0] v);
      if (v[0])      return DIR_NS;
      else if (v[1]) return DIR_SN;
      else if (v[2]) return DIR_EW;
      else           return DIR_WE;
   endfunction

endpackage

// File: rtl/lamp_tracker.sv
// Per-direction lamp tracker: previous-code register, dwell counter and
// combinational violation flags for one lamp.
//   clk, clear      : clock, async active-high reset
//   capture         : load baseline (prev <= cur, dwell <= 1), no checks
//   update          : normal tracking in RUN
//   cur             : current lamp code
//   *_c             : combinational flags comparing cur against prev/dwell
module lamp_tracker
   import traffic_light_pkg::*;
#(
   parameter int unsigned MIN_GREEN = 3,
   parameter int unsigned MAX_DWELL = 20,
   parameter int unsigned CNT_W     = 8
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              capture,
   input  logic              update,
   input  logic [LAMP_W-1:0] cur,
   output logic              illegal_c,
   output logic              bad_seq_c,
   output logic              short_green_c,
   output logic              stuck_c,
   output logic              is_nonred_c,
   output logic              y_to_r_c
);

   logic [LAMP_W-1:0] prev;
   logic [CNT_W-1:0]  dwell;
   logic              legal_step;

   // Only RED->GREEN, GREEN->YELLOW and YELLOW->RED are legal changes.
   assign legal_step = ((prev == RED)    && (cur == GREEN))  ||
                       ((prev == GREEN)  && (cur == YELLOW)) ||
                       ((prev == YELLOW) && (cur == RED));

   assign illegal_c     = (cur == 2'b11);
   assign bad_seq_c     = (cur != prev) && !legal_step;
   assign short_green_c = (prev == GREEN) && (cur != GREEN) &&
                          (dwell < CNT_W'(MIN_GREEN));
   // dwell+1 > MAX_DWELL, written without widening the counter.
   assign stuck_c       = (cur == prev) && ((cur == GREEN) || (cur == YELLOW)) &&
                          (dwell >= CNT_W'(MAX_DWELL));
   assign is_nonred_c   = (cur != RED);
   assign y_to_r_c      = (prev == YELLOW) && (cur == RED);

   // Prev code and saturating dwell counter.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         prev  <= RED;
         dwell <= '0;
      end else if (capture) begin
         prev  <= cur;
         dwell <= CNT_W'(1);
      end else if (update) begin
         prev <= cur;
         if (cur != prev)
            dwell <= CNT_W'(1);
         else if (dwell != '1)
            dwell <= dwell + CNT_W'(1);
      end
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the four lamp outputs of the traffic light controller.
// Latches the first violation (code + direction) until clear and counts
// completed NS rotations.
//   clk, clear         : clock, async active-high reset
//   ns, sn, ew, we     : lamp codes, direction index 0..3
//   fault              : sticky fault flag
//   fault_code         : first fault cause (0 = none)
//   fault_dir          : direction of first fault
//   rotations          : saturating count of NS YELLOW->RED transitions
//   armed              : high while checking (RUN)
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int unsigned MIN_GREEN = 3,
   parameter int unsigned MAX_DWELL = 20,
   parameter int unsigned CNT_W     = 8
) (
   input  logic              clk,
   input  logic              clear,
   input  logic [LAMP_W-1:0] ns,
   input  logic [LAMP_W-1:0] sn,
   input  logic [LAMP_W-1:0] ew,
   input  logic [LAMP_W-1:0] we,
   output logic              fault,
   output logic [CODE_W-1:0] fault_code,
   output logic [DIR_W-1:0]  fault_dir,
   output logic [ROT_W-1:0]  rotations,
   output logic              armed
);

   mon_state_t                   state;
   logic [NDIR-1:0][LAMP_W-1:0]  lamps;
   logic [NDIR-1:0]              illegal, bad_seq, short_green, stuck, nonred, y_to_r;
   logic                         conflict;
   logic                         viol;
   logic [CODE_W-1:0]            vcode;
   logic [DIR_W-1:0]             vdir;
   logic                         unused_y_to_r;

   assign lamps = {we, ew, sn, ns};

   for (genvar i = 0; i < NDIR; i++) begin : g_lamp
      lamp_tracker #(
         .MIN_GREEN (MIN_GREEN),
         .MAX_DWELL (MAX_DWELL),
         .CNT_W     (CNT_W)
      ) u_tracker (
         .clk           (clk),
         .clear         (clear),
         .capture       (state == ST_ARM),
         .update        (state == ST_RUN),
         .cur           (lamps[i]),
         .illegal_c     (illegal[i]),
         .bad_seq_c     (bad_seq[i]),
         .short_green_c (short_green[i]),
         .stuck_c       (stuck[i]),
         .is_nonred_c   (nonred[i]),
         .y_to_r_c      (y_to_r[i])
      );
   end

   // Only the NS lamp defines a rotation.
   assign unused_y_to_r = ^y_to_r[NDIR-1:1];

   assign conflict = (nonred[DIR_NS] | nonred[DIR_SN]) & (nonred[DIR_EW] | nonred[DIR_WE]);

   // Priority: lowest code first, then lowest direction.
   always_comb begin
      viol  = 1'b0;
      vcode = FC_NONE;
      vdir  = DIR_NS;
      if (|illegal) begin
         viol  = 1'b1;
         vcode = FC_ILLEGAL;
         vdir  = lowest_dir(illegal);
      end else if (|bad_seq) begin
         viol  = 1'b1;
         vcode = FC_BAD_SEQ;
         vdir  = lowest_dir(bad_seq);
      end else if (conflict) begin
         viol  = 1'b1;
         vcode = FC_CONFLICT;
         vdir  = lowest_dir(nonred);
      end else if (|short_green) begin
         viol  = 1'b1;
         vcode = FC_SHORT_GREEN;
         vdir  = lowest_dir(short_green);
      end else if (|stuck) begin
         viol  = 1'b1;
         vcode = FC_STUCK;
         vdir  = lowest_dir(stuck);
      end
   end

   // Monitor FSM with registered outputs; FAULT holds until clear.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state      <= ST_IDLE;
         fault      <= 1'b0;
         fault_code <= FC_NONE;
         fault_dir  <= DIR_NS;
         rotations  <= '0;
         armed      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_ARM;
            ST_ARM: begin
               state <= ST_RUN;
               armed <= 1'b1;
            end
            ST_RUN: begin
               if (y_to_r[DIR_NS] && (rotations != '1))
                  rotations <= rotations + ROT_W'(1);
               if (viol) begin
                  state      <= ST_FAULT;
                  fault      <= 1'b1;
                  fault_code <= vcode;
                  fault_dir  <= vdir;
                  armed      <= 1'b0;
               end
            end
            ST_FAULT: state <= ST_FAULT;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule
